// File: rtl/gpio_cond_pkg.sv
// gpio_cond_pkg: shared sizing helper and parameter legality check for the GPIO input conditioner
package gpio_cond_pkg;
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
  function automatic bit params_ok(input int sync_stages, input int debounce_cycles);
    return (sync_stages >= 2) && (debounce_cycles >= 1);
  endfunction
endpackage

// File: rtl/gpio_input_conditioner_if.sv
// gpio_input_conditioner_if: pad inputs, debounced levels, edge pulses and interrupt controls
interface gpio_input_conditioner_if #(parameter int WIDTH = 4);
  logic [WIDTH-1:0] pad_in;
  logic [WIDTH-1:0] gpio_read;
  logic [WIDTH-1:0] rise_pulse;
  logic [WIDTH-1:0] fall_pulse;
  logic [WIDTH-1:0] irq_rise_en;
  logic [WIDTH-1:0] irq_fall_en;
  logic [WIDTH-1:0] irq_clear;
  logic [WIDTH-1:0] irq_pending;
  logic irq;
  modport master (
    output pad_in, irq_rise_en, irq_fall_en, irq_clear,
    input gpio_read, rise_pulse, fall_pulse, irq_pending, irq
  );
  modport slave (
    input pad_in, irq_rise_en, irq_fall_en, irq_clear,
    output gpio_read, rise_pulse, fall_pulse, irq_pending, irq
  );
endinterface

// File: rtl/gpio_debounce_bit.sv
// gpio_debounce_bit: synchronise, debounce and edge-detect one pad input
module gpio_debounce_bit
  import gpio_cond_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pad,
  output logic level,
  output logic rise,
  output logic fall
);
  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0] cnt;
  logic sync_q;
  logic accept;
  assign sync_q = sync[SYNC_STAGES-1];
  assign accept = (sync_q != level) && (cnt == LAST);
  // plain flop chain into the clock domain, no logic between stages
  always_ff @(posedge clk or posedge rst)
    if (rst) sync <= {SYNC_STAGES{RESET_LEVEL}};
    else sync <= {sync[SYNC_STAGES-2:0], pad};
  // count consecutive mismatches; any agreement restarts the count
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      level <= RESET_LEVEL;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      cnt <= (sync_q == level || accept) ? '0 : cnt + 1'b1;
      level <= accept ? sync_q : level;
      rise <= accept & sync_q;
      fall <= accept & ~sync_q;
    end
endmodule

// File: rtl/gpio_input_conditioner.sv
// gpio_input_conditioner: per-bit debounced GPIO inputs with sticky maskable edge interrupts
module gpio_input_conditioner
  import gpio_cond_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter logic [WIDTH-1:0] RESET_LEVEL = {WIDTH{1'b0}}
) (
  input logic io_systemClk,
  input logic io_asyncReset,
  gpio_input_conditioner_if.slave bus
);
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] pending;
  logic irq_q;
  if (!params_ok(SYNC_STAGES, DEBOUNCE_CYCLES)) begin : g_bad_params
    $error("gpio_input_conditioner: SYNC_STAGES must be >= 2 and DEBOUNCE_CYCLES >= 1");
  end
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    gpio_debounce_bit #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_LEVEL(RESET_LEVEL[i])
    ) u_bit (
      .clk(io_systemClk),
      .rst(io_asyncReset),
      .pad(bus.pad_in[i]),
      .level(level[i]),
      .rise(rise[i]),
      .fall(fall[i])
    );
  end
  // sticky events from the registered pulses; a new event beats a same-cycle clear
  always_ff @(posedge io_systemClk or posedge io_asyncReset)
    if (io_asyncReset) begin
      pending <= '0;
      irq_q <= 1'b0;
    end else begin
      pending <= (pending & ~bus.irq_clear) | (rise & bus.irq_rise_en) | (fall & bus.irq_fall_en);
      irq_q <= |pending;
    end
  assign bus.gpio_read = level;
  assign bus.rise_pulse = rise;
  assign bus.fall_pulse = fall;
  assign bus.irq_pending = pending;
  assign bus.irq = irq_q;
endmodule

// File: tb/tb_gpio_input_conditioner.sv
// tb_gpio_input_conditioner: directed scoreboard bench for the GPIO input conditioner
module tb_gpio_input_conditioner;
  typedef struct {
    string tag;
    logic [3:0] gr;
    logic [3:0] rp;
    logic [3:0] fp;
    logic [3:0] pd;
    logic iq;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int compared = 0;
  int mismatched = 0;
  exp_t q[$];
  gpio_input_conditioner_if #(.WIDTH(4)) bus ();
  gpio_input_conditioner #(
    .WIDTH(4),
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4),
    .RESET_LEVEL(4'b0000)
  ) dut (
    .io_systemClk(clk),
    .io_asyncReset(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic push(input int n, input string tag, input logic [3:0] gr, input logic [3:0] rp,
                      input logic [3:0] fp, input logic [3:0] pd, input logic iq);
    exp_t e;
    e.tag = tag; e.gr = gr; e.rp = rp; e.fp = fp; e.pd = pd; e.iq = iq;
    for (int k = 0; k < n; k++) q.push_back(e);
  endtask
  task automatic check_front();
    exp_t e;
    if (q.size() == 0) begin
      compared++;
      mismatched++;
      $error("FAIL scoreboard_empty got 0 entries exp at least 1");
      return;
    end
    e = q.pop_front();
    compared += 5;
    assert (bus.gpio_read === e.gr) else begin
      mismatched++;
      $error("FAIL %s gpio_read got %b exp %b", e.tag, bus.gpio_read, e.gr);
    end
    assert (bus.rise_pulse === e.rp) else begin
      mismatched++;
      $error("FAIL %s rise_pulse got %b exp %b", e.tag, bus.rise_pulse, e.rp);
    end
    assert (bus.fall_pulse === e.fp) else begin
      mismatched++;
      $error("FAIL %s fall_pulse got %b exp %b", e.tag, bus.fall_pulse, e.fp);
    end
    assert (bus.irq_pending === e.pd) else begin
      mismatched++;
      $error("FAIL %s irq_pending got %b exp %b", e.tag, bus.irq_pending, e.pd);
    end
    assert (bus.irq === e.iq) else begin
      mismatched++;
      $error("FAIL %s irq got %b exp %b", e.tag, bus.irq, e.iq);
    end
  endtask
  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      check_front();
    end
  endtask
  initial begin
    bus.pad_in = 4'b0000;
    bus.irq_rise_en = 4'b0000;
    bus.irq_fall_en = 4'b0000;
    bus.irq_clear = 4'b0000;
    #1;
    push(1, "reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    check_front();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    push(2, "idle", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    run(2);
    bus.pad_in = 4'b0001;
    push(5, "rise0_wait", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    push(1, "rise0_edge", 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0);
    push(2, "rise0_hold", 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    run(8);
    bus.pad_in = 4'b0011;
    push(3, "glitch1_hi", 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    run(3);
    bus.pad_in = 4'b0001;
    push(8, "glitch1_lo", 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    run(8);
    bus.irq_fall_en = 4'b0100;
    bus.pad_in = 4'b0101;
    push(5, "rise2_wait", 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    push(1, "rise2_edge", 4'b0101, 4'b0100, 4'b0000, 4'b0000, 1'b0);
    push(1, "rise2_hold", 4'b0101, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    run(7);
    bus.pad_in = 4'b0001;
    push(5, "fall2_wait", 4'b0101, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    push(1, "fall2_edge", 4'b0001, 4'b0000, 4'b0100, 4'b0000, 1'b0);
    push(1, "fall2_pend", 4'b0001, 4'b0000, 4'b0000, 4'b0100, 1'b0);
    push(1, "fall2_irq", 4'b0001, 4'b0000, 4'b0000, 4'b0100, 1'b1);
    run(8);
    bus.irq_clear = 4'b0100;
    push(1, "clr2_pend", 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    run(1);
    bus.irq_clear = 4'b0000;
    push(2, "clr2_irq", 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    run(2);
    bus.irq_rise_en = 4'b1000;
    bus.pad_in = 4'b1001;
    push(5, "rise3_wait", 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    push(1, "rise3_edge", 4'b1001, 4'b1000, 4'b0000, 4'b0000, 1'b0);
    run(6);
    bus.irq_clear = 4'b1000;
    push(1, "set_wins", 4'b1001, 4'b0000, 4'b0000, 4'b1000, 1'b0);
    run(1);
    bus.irq_clear = 4'b0000;
    push(1, "set_wins_irq", 4'b1001, 4'b0000, 4'b0000, 4'b1000, 1'b1);
    run(1);
    bus.irq_rise_en = 4'b0000;
    push(2, "en_off_keeps", 4'b1001, 4'b0000, 4'b0000, 4'b1000, 1'b1);
    run(2);
    bus.irq_clear = 4'b1000;
    push(1, "clr3_pend", 4'b1001, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    run(1);
    bus.irq_clear = 4'b0000;
    push(1, "clr3_irq", 4'b1001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    run(1);
    bus.pad_in = 4'b1000;
    push(5, "fall0_wait", 4'b1001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    push(1, "fall0_edge", 4'b1000, 4'b0000, 4'b0001, 4'b0000, 1'b0);
    push(1, "fall0_hold", 4'b1000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    run(7);
    bus.pad_in = 4'b1001;
    push(4, "mid_count", 4'b1000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    run(4);
    rst = 1'b1;
    #1;
    push(1, "async_reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    check_front();
    @(posedge clk);
    #1;
    rst = 1'b0;
    push(5, "post_rst_wait", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    push(1, "post_rst_edge", 4'b1001, 4'b1001, 4'b0000, 4'b0000, 1'b0);
    push(1, "post_rst_hold", 4'b1001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    run(7);
    bus.pad_in = 4'b0000;
    push(5, "dual_fall_wait", 4'b1001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    push(1, "dual_fall_edge", 4'b0000, 4'b0000, 4'b1001, 4'b0000, 1'b0);
    push(1, "dual_fall_hold", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    run(7);
    bus.pad_in = 4'b1001;
    push(5, "dual_rise_wait", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    push(1, "dual_rise_edge", 4'b1001, 4'b1001, 4'b0000, 4'b0000, 1'b0);
    push(1, "dual_rise_hold", 4'b1001, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    run(7);
    compared++;
    assert (q.size() == 0) else begin
      mismatched++;
      $error("FAIL scoreboard_drain got %0d entries exp 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
